cpu_bank_reg: RTL and testbench
===============================

CPU_BANK_REG -- requirements
Module: cpu_bank_reg

Interface
REQ-001 Parameter NUM_REGS, default `NUM_REGS, number of architectural registers.
REQ-002 Parameter REG_WIDTH, default `REG_WIDTH, data width in bits.
REQ-003 Parameter AW, default $clog2(NUM_REGS), register index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 read_reg_a  input  AW  index for read port A.
REQ-007 read_reg_b  input  AW  index for read port B.
REQ-008 write_reg  input  AW  index for ALU write port.
REQ-009 write_data  input  REG_WIDTH  ALU write data.
REQ-010 write_enable  input  1  ALU write strobe.
REQ-011 write_reg_mul  input  AW  index for MUL write port.
REQ-012 write_data_mul  input  REG_WIDTH  MUL write data.
REQ-013 write_enable_mul  input  1  MUL write strobe.
REQ-014 read_data_a  output  REG_WIDTH  contents selected by read_reg_a.
REQ-015 read_data_b  output  REG_WIDTH  contents selected by read_reg_b.
REQ-016 The port set SHALL match the slave modport of CPU_bank_reg_if signal for signal; clk/reset_n are separate ports.

Function
REQ-017 Storage SHALL be NUM_REGS registers of REG_WIDTH bits; all indices 0..NUM_REGS-1 are writable.
REQ-018 read_data_a/read_data_b SHALL be combinational functions of read index and stored contents (zero-cycle read latency).
REQ-019 On a rising edge with write_enable=1, register[write_reg] SHALL take write_data.
REQ-020 On a rising edge with write_enable_mul=1, register[write_reg_mul] SHALL take write_data_mul.
REQ-021 Both strobes high, different indices: both writes SHALL commit in the same edge.
REQ-022 Both strobes high, same index: ALU port SHALL win (MUL result is the older instruction); MUL data is discarded.
REQ-023 Strobe low: corresponding index/data SHALL be ignored, including X values.
REQ-024 Out-of-range indices (>= NUM_REGS when NUM_REGS is not a power of two): writes SHALL be dropped, reads SHALL return 0.
REQ-025 Both read ports SHALL be independent; identical indices return identical data.

Reset
REQ-026 reset_n=0 SHALL clear every register to 0 immediately, independent of clk.
REQ-027 While reset_n=0, writes SHALL be ignored and read ports SHALL return 0 (or bypassed data per REQ-029 is suppressed).
REQ-028 Release of reset_n SHALL take effect at the next rising edge; a write strobed on that edge commits.

Configuration
REQ-029 Macro CPU_BANK_REG_BYPASS_EN defined: a read whose index matches an active write strobe in the same cycle SHALL return that write's data, ALU match taking priority over MUL match.
REQ-030 Macro undefined: reads SHALL return stored contents only; a written value becomes visible the cycle after the write edge.

Structure
REQ-031 Shared package cpu_bank_reg_pkg SHALL hold reg_idx_t (AW bits), reg_data_t (REG_WIDTH bits) and the write-port priority constant.
REQ-032 One sub-module cpu_bank_reg_rdport (read mux plus optional bypass) SHALL be instantiated twice, for ports A and B.

Verification
REQ-033 Reset: assert reset_n=0 mid-run after writing r3=0xDEAD -> read_data_a at index 3 reads 0 with no clock edge.
REQ-034 Dual write: ALU r1=0x1111, MUL r2=0x2222 same edge -> next cycle A(r1)=0x1111, B(r2)=0x2222.
REQ-035 Collision: ALU r5=0xAAAA and MUL r5=0x5555 same edge -> r5 reads 0xAAAA afterwards.
REQ-036 Bypass: r7 holds 0x0007; ALU writes r7=0x0070 while A reads r7 -> A=0x0070 same cycle with CPU_BANK_REG_BYPASS_EN, 0x0007 without; 0x0070 next cycle in both builds.
REQ-037 Bypass priority: ALU r4=0x4444 and MUL r4=0x9999 same cycle, B reads r4 -> B=0x4444 (bypass build).
REQ-038 Disabled strobe: write_enable=0 with write_reg=2, write_data=0xFFFF -> r2 unchanged.

Source files
------------

// File: rtl/cpu_bank_reg_pkg.sv
// Shared types and constants for the CPU register bank.
// Defaults for NUM_REGS / REG_WIDTH come from same-named macros when not
// supplied by the build. Optional feature macro: CPU_BANK_REG_BYPASS_EN.
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

package cpu_bank_reg_pkg;

   localparam int PKG_NUM_REGS  = `NUM_REGS;
   localparam int PKG_REG_WIDTH = `REG_WIDTH;
   localparam int PKG_AW        = $clog2(PKG_NUM_REGS);

   typedef logic [PKG_AW-1:0]        reg_idx_t;
   typedef logic [PKG_REG_WIDTH-1:0] reg_data_t;

   // On a same-index collision the ALU result is younger than the MUL result.
   typedef enum logic {
      WR_PRIO_ALU = 1'b0,
      WR_PRIO_MUL = 1'b1
   } wr_prio_e;

   localparam wr_prio_e WR_PRIO = WR_PRIO_ALU;

endpackage

// File: rtl/cpu_bank_reg_rdport.sv
// One read port of the CPU register bank: index mux over the stored
// contents, plus an optional write-to-read bypass when
// CPU_BANK_REG_BYPASS_EN is defined. Out-of-range indices read 0.
module cpu_bank_reg_rdport
   import cpu_bank_reg_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_WIDTH = 16,
   parameter int AW        = $clog2(NUM_REGS)
) (
   input  logic                          reset_n,
   input  logic [AW-1:0]                 rd_idx,
   input  logic [NUM_REGS*REG_WIDTH-1:0] regs_flat,
   input  logic [AW-1:0]                 wr_idx,
   input  logic [REG_WIDTH-1:0]          wr_data,
   input  logic                          wr_en,
   input  logic [AW-1:0]                 wr_idx_mul,
   input  logic [REG_WIDTH-1:0]          wr_data_mul,
   input  logic                          wr_en_mul,
   output logic [REG_WIDTH-1:0]          rd_data
);

   logic [REG_WIDTH-1:0] stored;

   // Select the stored register; indices with no register fall through to 0.
   always_comb begin
      stored = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == AW'(i)) stored = regs_flat[i*REG_WIDTH +: REG_WIDTH];
      end
   end

`ifdef CPU_BANK_REG_BYPASS_EN
   logic in_range;
   logic hit_alu;
   logic hit_mul;

   // Forward same-cycle write data; suppressed in reset and for dropped writes.
   always_comb begin
      in_range = int'(rd_idx) < NUM_REGS;
      hit_alu  = reset_n && in_range && wr_en     && (wr_idx     == rd_idx);
      hit_mul  = reset_n && in_range && wr_en_mul && (wr_idx_mul == rd_idx);
      rd_data  = stored;
      if (WR_PRIO == WR_PRIO_ALU) begin
         if (hit_alu)      rd_data = wr_data;
         else if (hit_mul) rd_data = wr_data_mul;
      end else begin
         if (hit_mul)      rd_data = wr_data_mul;
         else if (hit_alu) rd_data = wr_data;
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{reset_n, wr_idx, wr_data, wr_en,
                            wr_idx_mul, wr_data_mul, wr_en_mul};
   assign rd_data = stored;
`endif

endmodule

// File: rtl/cpu_bank_reg.sv
// CPU architectural register bank: two combinational read ports, an ALU
// write port and a MUL write port (ALU wins on same-index collisions).
// Optional same-cycle read bypass under macro CPU_BANK_REG_BYPASS_EN.
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

module cpu_bank_reg
   import cpu_bank_reg_pkg::*;
#(
   parameter int NUM_REGS  = `NUM_REGS,
   parameter int REG_WIDTH = `REG_WIDTH,
   parameter int AW        = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [AW-1:0]        read_reg_a,
   input  logic [AW-1:0]        read_reg_b,
   input  logic [AW-1:0]        write_reg,
   input  logic [REG_WIDTH-1:0] write_data,
   input  logic                 write_enable,
   input  logic [AW-1:0]        write_reg_mul,
   input  logic [REG_WIDTH-1:0] write_data_mul,
   input  logic                 write_enable_mul,
   output logic [REG_WIDTH-1:0] read_data_a,
   output logic [REG_WIDTH-1:0] read_data_b
);

   logic [REG_WIDTH-1:0]          regs_q [NUM_REGS];
   logic [REG_WIDTH-1:0]          regs_d [NUM_REGS];
   logic [NUM_REGS*REG_WIDTH-1:0] regs_flat;

   // Next contents: the lower-priority port is applied first so the other overrides it.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (WR_PRIO == WR_PRIO_ALU) begin
            if (write_enable_mul && (write_reg_mul == AW'(i))) regs_d[i] = write_data_mul;
            if (write_enable     && (write_reg     == AW'(i))) regs_d[i] = write_data;
         end else begin
            if (write_enable     && (write_reg     == AW'(i))) regs_d[i] = write_data;
            if (write_enable_mul && (write_reg_mul == AW'(i))) regs_d[i] = write_data_mul;
         end
      end
   end

   // Register storage, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
   end

   cpu_bank_reg_rdport #(
      .NUM_REGS  (NUM_REGS),
      .REG_WIDTH (REG_WIDTH),
      .AW        (AW)
   ) u_rdport_a (
      .reset_n     (reset_n),
      .rd_idx      (read_reg_a),
      .regs_flat   (regs_flat),
      .wr_idx      (write_reg),
      .wr_data     (write_data),
      .wr_en       (write_enable),
      .wr_idx_mul  (write_reg_mul),
      .wr_data_mul (write_data_mul),
      .wr_en_mul   (write_enable_mul),
      .rd_data     (read_data_a)
   );

   cpu_bank_reg_rdport #(
      .NUM_REGS  (NUM_REGS),
      .REG_WIDTH (REG_WIDTH),
      .AW        (AW)
   ) u_rdport_b (
      .reset_n     (reset_n),
      .rd_idx      (read_reg_b),
      .regs_flat   (regs_flat),
      .wr_idx      (write_reg),
      .wr_data     (write_data),
      .wr_en       (write_enable),
      .wr_idx_mul  (write_reg_mul),
      .wr_data_mul (write_data_mul),
      .wr_en_mul   (write_enable_mul),
      .rd_data     (read_data_b)
   );

endmodule

// File: tb/tb_cpu_bank_reg.sv
// Directed bench for cpu_bank_reg: 16x16 main instance plus a 12-entry
// instance (same inputs) for out-of-range index behaviour.
module tb_cpu_bank_reg;

`ifdef CPU_BANK_REG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [3:0]  read_reg_a, read_reg_b, write_reg, write_reg_mul;
   logic [15:0] write_data, write_data_mul;
   logic        write_enable, write_enable_mul;
   logic [15:0] read_data_a, read_data_b;
   logic [15:0] read_data_a2, read_data_b2;

   int checks = 0;
   int errors = 0;

   cpu_bank_reg #(.NUM_REGS(16), .REG_WIDTH(16), .AW(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .read_reg_a       (read_reg_a),
      .read_reg_b       (read_reg_b),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .write_enable     (write_enable),
      .write_reg_mul    (write_reg_mul),
      .write_data_mul   (write_data_mul),
      .write_enable_mul (write_enable_mul),
      .read_data_a      (read_data_a),
      .read_data_b      (read_data_b)
   );

   cpu_bank_reg #(.NUM_REGS(12), .REG_WIDTH(16), .AW(4)) dut12 (
      .clk              (clk),
      .reset_n          (reset_n),
      .read_reg_a       (read_reg_a),
      .read_reg_b       (read_reg_b),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .write_enable     (write_enable),
      .write_reg_mul    (write_reg_mul),
      .write_data_mul   (write_data_mul),
      .write_enable_mul (write_enable_mul),
      .read_data_a      (read_data_a2),
      .read_data_b      (read_data_b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b1;
      read_reg_a = '0; read_reg_b = '0;
      write_reg = '0; write_data = '0; write_enable = 1'b0;
      write_reg_mul = '0; write_data_mul = '0; write_enable_mul = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("reset_a", read_data_a, 16'h0000);
      chk("reset_b", read_data_b, 16'h0000);

      // Release with a write on the first edge
      @(negedge clk);
      reset_n = 1'b1;
      write_enable = 1'b1; write_reg = 4'd3; write_data = 16'hDEAD; read_reg_a = 4'd3;
      @(posedge clk); #1;
      chk("release_write", read_data_a, 16'hDEAD);
      @(negedge clk);
      write_enable = 1'b0;
      #1 chk("r3_held", read_data_a, 16'hDEAD);

      // Asynchronous reset mid-cycle, no clock edge in between
      #1 reset_n = 1'b0;
      #1 chk("async_reset", read_data_a, 16'h0000);
      write_enable = 1'b1; write_reg = 4'd3; write_data = 16'hBEEF;
      #1 chk("reset_no_bypass", read_data_a, 16'h0000);
      @(posedge clk); #1;
      chk("reset_write_ignored", read_data_a, 16'h0000);
      @(negedge clk);
      write_enable = 1'b0; reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset", read_data_a, 16'h0000);

      // Dual write, different indices
      @(negedge clk);
      write_enable = 1'b1;     write_reg = 4'd1;     write_data = 16'h1111;
      write_enable_mul = 1'b1; write_reg_mul = 4'd2; write_data_mul = 16'h2222;
      @(negedge clk);
      write_enable = 1'b0; write_enable_mul = 1'b0;
      read_reg_a = 4'd1; read_reg_b = 4'd2;
      #1;
      chk("dual_a_r1", read_data_a, 16'h1111);
      chk("dual_b_r2", read_data_b, 16'h2222);

      // Same-index collision: ALU wins
      @(negedge clk);
      write_enable = 1'b1;     write_reg = 4'd5;     write_data = 16'hAAAA;
      write_enable_mul = 1'b1; write_reg_mul = 4'd5; write_data_mul = 16'h5555;
      @(negedge clk);
      write_enable = 1'b0; write_enable_mul = 1'b0; read_reg_a = 4'd5;
      #1 chk("collision_r5", read_data_a, 16'hAAAA);

      // Bypass of ALU write to port A
      @(negedge clk);
      write_enable = 1'b1; write_reg = 4'd7; write_data = 16'h0007;
      @(negedge clk);
      write_data = 16'h0070; read_reg_a = 4'd7;
      #1 chk("bypass_same_cycle", read_data_a, BYP ? 16'h0070 : 16'h0007);
      @(posedge clk); #1;
      chk("bypass_after_edge", read_data_a, 16'h0070);
      @(negedge clk);
      write_enable = 1'b0;
      #1 chk("r7_next_cycle", read_data_a, 16'h0070);

      // Bypass priority on port B
      write_enable = 1'b1;     write_reg = 4'd4;     write_data = 16'h4444;
      write_enable_mul = 1'b1; write_reg_mul = 4'd4; write_data_mul = 16'h9999;
      read_reg_b = 4'd4;
      #1 chk("bypass_prio_b", read_data_b, BYP ? 16'h4444 : 16'h0000);
      @(negedge clk);
      write_enable = 1'b0; write_enable_mul = 1'b0;
      #1 chk("r4_committed", read_data_b, 16'h4444);

      // MUL-only bypass
      write_enable_mul = 1'b1; write_reg_mul = 4'd6; write_data_mul = 16'h6666;
      read_reg_a = 4'd6;
      #1 chk("bypass_mul_a", read_data_a, BYP ? 16'h6666 : 16'h0000);
      @(negedge clk);
      write_enable_mul = 1'b0;
      #1 chk("r6_committed", read_data_a, 16'h6666);

      // Disabled strobes with junk index/data
      write_enable = 1'b0; write_reg = 4'd2; write_data = 16'hFFFF;
      write_enable_mul = 1'b0; write_reg_mul = 'x; write_data_mul = 'x;
      read_reg_b = 4'd2;
      @(negedge clk);
      #1 chk("disabled_r2", read_data_b, 16'h2222);
      write_reg_mul = '0; write_data_mul = '0;

      // Both ports on the same index
      read_reg_a = 4'd1; read_reg_b = 4'd1;
      #1;
      chk("same_idx_a", read_data_a, 16'h1111);
      chk("same_idx_b", read_data_b, 16'h1111);

      // Index extremes
      @(negedge clk);
      write_enable = 1'b1;     write_reg = 4'd15;    write_data = 16'hF00F;
      write_enable_mul = 1'b1; write_reg_mul = 4'd0; write_data_mul = 16'h0F0F;
      @(negedge clk);
      write_enable = 1'b0; write_enable_mul = 1'b0;
      read_reg_a = 4'd15; read_reg_b = 4'd0;
      #1;
      chk("r15", read_data_a, 16'hF00F);
      chk("r0", read_data_b, 16'h0F0F);

      // Out-of-range index on the 12-entry instance
      @(negedge clk);
      write_enable = 1'b1;     write_reg = 4'd12;     write_data = 16'h1234;
      write_enable_mul = 1'b1; write_reg_mul = 4'd11; write_data_mul = 16'hBBBB;
      read_reg_a = 4'd12;
      #1 chk("oor_no_bypass", read_data_a2, 16'h0000);
      @(negedge clk);
      write_enable = 1'b0; write_enable_mul = 1'b0; read_reg_b = 4'd11;
      #1;
      chk("oor_read_zero", read_data_a2, 16'h0000);
      chk("r12_main", read_data_a, 16'h1234);
      chk("r11_small", read_data_b2, 16'hBBBB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
